// File: rtl/timer_pkg.sv
// Shared definitions for the timer/counter: FSM states, register map,
// CTRL field layout and mode codes.
package timer_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
   localparam logic [ADDR_W-1:0] ADDR_PRESET = 2'd1;
   localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'd2;

   localparam int unsigned CTRL_EN_BIT  = 0;
   localparam int unsigned CTRL_MODE_LO = 1;
   localparam int unsigned CTRL_MODE_HI = 2;
   localparam int unsigned CTRL_IM_BIT  = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   typedef struct packed {
      logic       im;
      logic [1:0] mode;
      logic       en;
   } ctrl_t;

   // Only the low nibble of a CTRL write carries fields; the rest is dropped.
   function automatic ctrl_t ctrl_from_word(input logic [3:0] w);
      ctrl_t c;
      c.en   = w[CTRL_EN_BIT];
      c.mode = w[CTRL_MODE_HI:CTRL_MODE_LO];
      c.im   = w[CTRL_IM_BIT];
      return c;
   endfunction

   function automatic logic [DATA_W-1:0] ctrl_to_word(input ctrl_t c);
      logic [DATA_W-1:0] w;
      w = '0;
      w[CTRL_EN_BIT]               = c.en;
      w[CTRL_MODE_HI:CTRL_MODE_LO] = c.mode;
      w[CTRL_IM_BIT]               = c.im;
      return w;
   endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer with one-shot and auto-reload
// modes and a level interrupt request.
module timer_counter
   import timer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              irq
);

   state_t            state, state_nxt;
   ctrl_t             ctrl, ctrl_nxt;
   logic [DATA_W-1:0] preset, preset_nxt;
   logic [DATA_W-1:0] count, count_nxt;
   logic              pending, pending_nxt;

   logic wr_ctrl;
   logic wr_preset;
   logic reload_mode;

   assign wr_ctrl     = we && (addr == ADDR_CTRL);
   assign wr_preset   = we && (addr == ADDR_PRESET);
   assign reload_mode = (ctrl.mode == MODE_RELOAD);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Register file and counter
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl    <= '0;
         preset  <= '0;
         count   <= '0;
         pending <= 1'b0;
      end else begin
         ctrl    <= ctrl_nxt;
         preset  <= preset_nxt;
         count   <= count_nxt;
         pending <= pending_nxt;
      end
   end

   // Next state and register updates; software writes are applied last so
   // they win over any FSM-side change on the same edge.
   always_comb begin
      state_nxt   = state;
      ctrl_nxt    = ctrl;
      preset_nxt  = preset;
      count_nxt   = count;
      pending_nxt = pending;

      case (state)
         ST_IDLE: begin
            if (ctrl.en) begin
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            count_nxt = preset;
            state_nxt = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl.en) begin
               state_nxt = ST_IDLE;
            end else if (count > DATA_W'(1)) begin
               count_nxt = count - DATA_W'(1);
            end else begin
               // Saturates at zero so PRESET=0 expires like PRESET=1.
               count_nxt   = '0;
               pending_nxt = 1'b1;
               state_nxt   = ST_INT;
            end
         end
         ST_INT: begin
            if (reload_mode) begin
               pending_nxt = 1'b0;
               state_nxt   = ST_LOAD;
            end else begin
               ctrl_nxt.en = 1'b0;
               state_nxt   = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (wr_ctrl) begin
         ctrl_nxt    = ctrl_from_word(din[3:0]);
         pending_nxt = 1'b0;
      end
      if (wr_preset) begin
         preset_nxt  = din;
         pending_nxt = 1'b0;
      end
   end

   // Zero-latency read mux
   always_comb begin
      dout = '0;
      case (addr)
         ADDR_CTRL:   dout = ctrl_to_word(ctrl);
         ADDR_PRESET: dout = preset;
         ADDR_COUNT:  dout = count;
         default:     dout = '0;
      endcase
   end

   assign irq = pending & ctrl.im;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: stimulus queues expected dout/irq,
// a negedge monitor pops and compares.
module tb_timer_counter;

   logic        clk;
   logic        reset;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   typedef struct {
      logic [31:0] d;
      logic        i;
   } exp_t;

   exp_t  exp_q[$];
   string nm_q[$];
   exp_t  cur;
   string cur_nm;
   int    passed = 0;
   int    total  = 0;

   // Auto-reload COUNT trace, PRESET=3, one entry per edge after EN=1 write.
   int unsigned ar_cnt [21] = '{0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0,
                                0, 3, 2, 1, 0, 0, 3, 2, 1, 0};

   timer_counter dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .din   (din),
      .dout  (dout),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur    = exp_q.pop_front();
         cur_nm = nm_q.pop_front();
         total  = total + 1;
         if (dout !== cur.d || irq !== cur.i) begin
            $display("FAIL %s: dout=%h (want %h) irq=%b (want %b) at %0t",
                     cur_nm, dout, cur.d, irq, cur.i, $time);
         end else begin
            passed = passed + 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr = a;
      din  = d;
      we   = 1'b1;
      step();
   endtask

   // Queue one expectation for the current cycle, then advance one edge.
   task automatic chk(input string nm, input logic [1:0] a,
                      input logic [31:0] d, input logic i);
      exp_t e;
      addr = a;
      e.d  = d;
      e.i  = i;
      exp_q.push_back(e);
      nm_q.push_back(nm);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, %0d/%0d so far", passed, total);
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      we    = 1'b0;
      addr  = 2'd0;
      din   = '0;
      step();
      step();
      reset = 1'b0;
      chk("rst_ctrl",   2'd0, 32'h0, 1'b0);
      chk("rst_preset", 2'd1, 32'h0, 1'b0);
      chk("rst_count",  2'd2, 32'h0, 1'b0);

      // One-shot, PRESET=5: irq rises 7 edges after EN write, holds until CTRL write
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);
      repeat (6) step();
      chk("os_pre",    2'd2, 32'd1, 1'b0);
      chk("os_rise",   2'd2, 32'd0, 1'b1);
      chk("os_en_clr", 2'd0, 32'h8, 1'b1);
      for (int k = 0; k < 18; k++) chk("os_hold", 2'd1, 32'd5, 1'b1);
      wr(2'd0, 32'h0);
      chk("os_clr_ctrl", 2'd0, 32'h0, 1'b0);
      chk("os_clr",      2'd2, 32'h0, 1'b0);

      // CTRL write on the INT edge keeps EN; PRESET write clears pending
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h9);
      repeat (3) step();
      wr(2'd0, 32'h9);
      for (int j = 4; j <= 7; j++) chk("sw_wins", 2'd0, 32'h9, (j == 7));
      wr(2'd1, 32'd1);
      chk("preset_clr", 2'd0, 32'h8, 1'b0);
      wr(2'd0, 32'h0);

      // Auto-reload, PRESET=3: 1-cycle pulse every 5 cycles
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);
      for (int j = 0; j <= 20; j++)
         chk("reload", 2'd2, 32'(ar_cnt[j]), (j > 0 && (j % 5) == 0));
      wr(2'd0, 32'h0);
      repeat (3) step();

      // Masked one-shot: EN self-clears, irq never asserts
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h1);
      for (int j = 0; j <= 7; j++)
         chk("masked", 2'd0, (j < 5) ? 32'h1 : 32'h0, 1'b0);
      chk("masked_cnt", 2'd2, 32'd0, 1'b0);

      // Pause then resume from a fresh LOAD
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h1);
      repeat (3) step();
      wr(2'd0, 32'h0);
      for (int k = 0; k < 3; k++) chk("paused", 2'd2, 32'd8, 1'b0);
      wr(2'd0, 32'h9);
      for (int j = 0; j <= 13; j++)
         chk("resume", 2'd2, (j < 2) ? 32'd8 : ((j < 12) ? 32'(12 - j) : 32'd0), (j >= 12));
      wr(2'd0, 32'h0);

      // PRESET=0 behaves like PRESET=1: irq at edge 3
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h9);
      for (int j = 0; j <= 4; j++) chk("preset0", 2'd2, 32'd0, (j >= 3));
      wr(2'd0, 32'h0);

      // Reset mid-count aborts with no irq
      wr(2'd1, 32'd6);
      wr(2'd0, 32'h9);
      repeat (3) step();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      chk("rstmid_ctrl",   2'd0, 32'h0, 1'b0);
      chk("rstmid_preset", 2'd1, 32'h0, 1'b0);
      for (int k = 0; k < 8; k++) chk("rstmid_cnt", 2'd2, 32'h0, 1'b0);

      // COUNT and reserved address are write-ignored; CTRL upper bits read 0
      wr(2'd1, 32'd7);
      wr(2'd0, 32'h1);
      step();
      step();
      wr(2'd0, 32'h0);
      step();
      wr(2'd2, 32'h55);
      wr(2'd3, 32'h1234);
      chk("count_ro",   2'd2, 32'd6, 1'b0);
      chk("rsvd_read",  2'd3, 32'h0, 1'b0);
      chk("preset_keep", 2'd1, 32'd7, 1'b0);
      wr(2'd0, 32'hFFFF_FFF6);
      chk("ctrl_hi_zero", 2'd0, 32'h6, 1'b0);
      wr(2'd0, 32'h0);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         $display("FAIL drain: %0d expectations left (want 0)", exp_q.size());
         total = total + exp_q.size();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
